// File: rtl/riscv_multicycle_top.sv
// Multi-cycle RV32I subset core: one FSM walks each instruction through
// FETCH/DECODE/EXECUTE/MEM/WB, with halt detection and a retired-instruction counter.
module riscv_multicycle_top #(
  parameter int                       ADDRESS_WIDTH = 32,
  parameter int                       DATA_WIDTH    = 32,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0,
  parameter int                       COUNT_WIDTH   = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic [ADDRESS_WIDTH-1:0] instr_addr,
  input  logic [31:0]              instr,
  output logic [ADDRESS_WIDTH-1:0] dmem_addr,
  output logic [DATA_WIDTH-1:0]    dmem_wdata,
  output logic                     dmem_we,
  input  logic [DATA_WIDTH-1:0]    dmem_rdata,
  output logic [DATA_WIDTH-1:0]    a0,
  output logic                     halted,
  output logic                     illegal,
  output logic [COUNT_WIDTH-1:0]   retired
);

  localparam logic [6:0]  OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0]  OPC_OP     = 7'b0110011;
  localparam logic [6:0]  OPC_LUI    = 7'b0110111;
  localparam logic [6:0]  OPC_LOAD   = 7'b0000011;
  localparam logic [6:0]  OPC_STORE  = 7'b0100011;
  localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
  localparam logic [6:0]  OPC_JAL    = 7'b1101111;
  localparam logic [6:0]  OPC_JALR   = 7'b1100111;
  localparam logic [31:0] HALT_WORD  = 32'h0000006F;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WB, S_HALT
  } state_t;

  state_t                   state;
  logic [ADDRESS_WIDTH-1:0] pc;
  logic [31:0]              ir;
  logic [DATA_WIDTH-1:0]    a_q, b_q, imm_q, res_q;
  logic [DATA_WIDTH-1:0]    regs [32];
  logic                     we_q;

  logic [6:0] opcode, funct7;
  logic [4:0] rd, rs1, rs2;
  logic [2:0] funct3;

  assign opcode = ir[6:0];
  assign rd     = ir[11:7];
  assign funct3 = ir[14:12];
  assign rs1    = ir[19:15];
  assign rs2    = ir[24:20];
  assign funct7 = ir[31:25];

  assign instr_addr = pc;
  // Masking with rst keeps a sw aborted in its MEM cycle from writing memory.
  assign dmem_we    = we_q && !rst;

  logic [31:0]           imm32;
  logic [DATA_WIDTH-1:0] imm_ext;

  always_comb begin
    imm32 = '0;
    case (opcode)
      OPC_OP_IMM, OPC_LOAD, OPC_JALR: imm32 = {{20{ir[31]}}, ir[31:20]};
      OPC_STORE:  imm32 = {{20{ir[31]}}, ir[31:25], ir[11:7]};
      OPC_BRANCH: imm32 = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      OPC_LUI:    imm32 = {ir[31:12], 12'b0};
      OPC_JAL:    imm32 = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
      default:    imm32 = '0;
    endcase
  end

  assign imm_ext = DATA_WIDTH'($signed(imm32));

  logic legal;

  always_comb begin
    legal = 1'b0;
    case (opcode)
      OPC_OP_IMM: legal = funct3 inside {3'b000, 3'b010, 3'b100, 3'b110, 3'b111};
      OPC_OP:     legal = (funct7 == 7'b0000000 &&
                           funct3 inside {3'b000, 3'b010, 3'b100, 3'b110, 3'b111}) ||
                          (funct7 == 7'b0100000 && funct3 == 3'b000);
      OPC_LUI, OPC_JAL:     legal = 1'b1;
      OPC_LOAD, OPC_STORE:  legal = (funct3 == 3'b010);
      OPC_BRANCH: legal = funct3 inside {3'b000, 3'b001, 3'b100};
      OPC_JALR:   legal = (funct3 == 3'b000);
      default:    legal = 1'b0;
    endcase
  end

  logic [DATA_WIDTH-1:0] alu_b, alu_y, sum_ai;
  logic                  alu_sub, taken;

  assign alu_b   = (opcode == OPC_OP) ? b_q : imm_q;
  assign alu_sub = (opcode == OPC_OP) && funct7[5];
  assign sum_ai  = a_q + imm_q;

  always_comb begin
    alu_y = '0;
    case (funct3)
      3'b000:  alu_y = alu_sub ? (a_q - alu_b) : (a_q + alu_b);
      3'b010:  alu_y = DATA_WIDTH'($signed(a_q) < $signed(alu_b));
      3'b100:  alu_y = a_q ^ alu_b;
      3'b110:  alu_y = a_q | alu_b;
      3'b111:  alu_y = a_q & alu_b;
      default: alu_y = '0;
    endcase
  end

  always_comb begin
    taken = 1'b0;
    case (funct3)
      3'b000:  taken = (a_q == b_q);
      3'b001:  taken = (a_q != b_q);
      3'b100:  taken = ($signed(a_q) < $signed(b_q));
      default: taken = 1'b0;
    endcase
  end

  logic [ADDRESS_WIDTH-1:0] pc_plus4, pc_plus_imm, jalr_tgt;

  assign pc_plus4    = pc + ADDRESS_WIDTH'(4);
  assign pc_plus_imm = pc + ADDRESS_WIDTH'(imm_q);
  assign jalr_tgt    = ADDRESS_WIDTH'(sum_ai) & ~ADDRESS_WIDTH'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_FETCH;
      pc         <= RESET_PC;
      ir         <= '0;
      a_q        <= '0;
      b_q        <= '0;
      imm_q      <= '0;
      res_q      <= '0;
      we_q       <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      a0         <= '0;
      halted     <= 1'b0;
      illegal    <= 1'b0;
      retired    <= '0;
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else begin
      we_q <= 1'b0;
      case (state)
        S_FETCH: begin
          ir    <= instr;
          state <= S_DECODE;
        end
        S_DECODE: begin
          a_q   <= regs[rs1];
          b_q   <= regs[rs2];
          imm_q <= imm_ext;
          if (ir == HALT_WORD || !legal) begin
            state   <= S_HALT;
            halted  <= 1'b1;
            illegal <= (ir != HALT_WORD);
            retired <= retired + COUNT_WIDTH'(1);
          end else begin
            state <= S_EXECUTE;
          end
        end
        S_EXECUTE: begin
          case (opcode)
            OPC_BRANCH: begin
              pc      <= taken ? pc_plus_imm : pc_plus4;
              retired <= retired + COUNT_WIDTH'(1);
              state   <= S_FETCH;
            end
            OPC_LOAD, OPC_STORE: begin
              dmem_addr  <= ADDRESS_WIDTH'(sum_ai);
              dmem_wdata <= b_q;
              we_q       <= (opcode == OPC_STORE);
              state      <= S_MEM;
            end
            OPC_LUI: begin
              res_q <= imm_q;
              state <= S_WB;
            end
            OPC_JAL, OPC_JALR: begin
              res_q <= DATA_WIDTH'(pc_plus4);
              state <= S_WB;
            end
            default: begin
              res_q <= alu_y;
              state <= S_WB;
            end
          endcase
        end
        S_MEM: begin
          if (opcode == OPC_STORE) begin
            pc      <= pc_plus4;
            retired <= retired + COUNT_WIDTH'(1);
            state   <= S_FETCH;
          end else begin
            res_q <= dmem_rdata;
            state <= S_WB;
          end
        end
        S_WB: begin
          if (rd != 5'd0) regs[rd] <= res_q;
          if (rd == 5'd10) a0 <= res_q;
          if (opcode == OPC_JAL)       pc <= pc_plus_imm;
          else if (opcode == OPC_JALR) pc <= jalr_tgt;
          else                         pc <= pc_plus4;
          retired <= retired + COUNT_WIDTH'(1);
          state   <= S_FETCH;
        end
        S_HALT: state <= S_HALT;
        default: state <= S_HALT;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_multicycle_top.sv
// Directed bench for riscv_multicycle_top: small programs from a local
// instruction ROM, hand-computed expectations checked at falling edges.
module tb_riscv_multicycle_top;

  logic        clk;
  logic        rst;
  logic [31:0] instr_addr;
  logic [31:0] instr;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_we;
  logic [31:0] dmem_rdata;
  logic [31:0] a0;
  logic        halted;
  logic        illegal;
  logic [31:0] retired;

  logic [31:0] imem [16];
  logic        rand_en;
  logic [31:0] instr_rand;
  int          n_vec;
  int          n_err;
  int          we_pulses;
  int          pulses_before;

  riscv_multicycle_top #(
    .ADDRESS_WIDTH(32),
    .DATA_WIDTH   (32),
    .RESET_PC     (32'h0),
    .COUNT_WIDTH  (32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .instr_addr(instr_addr),
    .instr     (instr),
    .dmem_addr (dmem_addr),
    .dmem_wdata(dmem_wdata),
    .dmem_we   (dmem_we),
    .dmem_rdata(dmem_rdata),
    .a0        (a0),
    .halted    (halted),
    .illegal   (illegal),
    .retired   (retired)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign instr = rand_en ? instr_rand :
                 (instr_addr < 32'd64) ? imem[instr_addr[5:2]] : 32'h0000007F;

  // counts write strobes at the edge where memory would commit them
  initial we_pulses = 0;
  always @(posedge clk) if (dmem_we === 1'b1) we_pulses <= we_pulses + 1;

  // driver tasks
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic hold_reset();
    rst = 1'b1;
    for (int i = 0; i < 16; i++) imem[i] = 32'h0000006F;
  endtask

  task automatic release_reset();
    step(2);
    rst = 1'b0;
  endtask

  // scoreboard
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    n_vec      = 0;
    n_err      = 0;
    rand_en    = 1'b1;
    instr_rand = $urandom();
    dmem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    hold_reset();
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      @(negedge clk);
      instr_rand = $urandom();
    end
    check("rst_instr_addr", instr_addr, 32'h0);
    check("rst_a0", a0, 32'h0);
    check("rst_halted", {31'b0, halted}, 32'h0);
    check("rst_illegal", {31'b0, illegal}, 32'h0);
    check("rst_retired", retired, 32'h0);
    check("rst_dmem_we", {31'b0, dmem_we}, 32'h0);
    check("rst_dmem_addr", dmem_addr, 32'h0);
    check("rst_dmem_wdata", dmem_wdata, 32'h0);

    // addi x10,x0,5 ; halt
    rand_en = 1'b0;
    imem[0] = 32'h00500513;
    rst = 1'b0;
    check("first_fetch_pc", instr_addr, 32'h0);
    step(4);
    check("addi_a0", a0, 32'd5);
    step(1);
    check("addi_not_halted_yet", {31'b0, halted}, 32'h0);
    step(1);
    check("addi_halted", {31'b0, halted}, 32'h1);
    check("addi_retired", retired, 32'd2);
    check("addi_illegal", {31'b0, illegal}, 32'h0);
    check("addi_halt_pc", instr_addr, 32'h4);

    // countdown loop
    hold_reset();
    imem[0] = 32'h00300513;
    imem[1] = 32'hFFF50513;
    imem[2] = 32'hFE051EE3;
    release_reset();
    step(4);
    check("loop_a0_3", a0, 32'd3);
    step(4);
    check("loop_a0_2", a0, 32'd2);
    step(7);
    check("loop_a0_1", a0, 32'd1);
    step(7);
    check("loop_a0_0", a0, 32'd0);
    step(4);
    check("loop_halted_26", {31'b0, halted}, 32'h0);
    step(1);
    check("loop_halted_27", {31'b0, halted}, 32'h1);
    check("loop_retired", retired, 32'd8);
    check("loop_halt_pc", instr_addr, 32'hC);

    // store / load
    hold_reset();
    imem[0] = 32'h123452B7;
    imem[1] = 32'h00502423;
    imem[2] = 32'h00802503;
    release_reset();
    pulses_before = we_pulses;
    step(6);
    check("sw_we_before", {31'b0, dmem_we}, 32'h0);
    step(1);
    check("sw_we", {31'b0, dmem_we}, 32'h1);
    check("sw_addr", dmem_addr, 32'h8);
    check("sw_wdata", dmem_wdata, 32'h12345000);
    step(1);
    check("sw_we_after", {31'b0, dmem_we}, 32'h0);
    step(4);
    check("lw_a0_before_wb", a0, 32'h0);
    step(1);
    check("lw_a0", a0, 32'hDEADBEEF);
    check("sw_pulse_count", we_pulses - pulses_before, 32'd1);
    step(2);
    check("ldst_halted", {31'b0, halted}, 32'h1);
    check("ldst_retired", retired, 32'd4);

    // x0 discard and illegal opcode
    hold_reset();
    imem[0] = 32'h00700513;
    imem[1] = 32'h00500013;
    imem[2] = 32'h00000513;
    imem[3] = 32'h0000007F;
    release_reset();
    step(4);
    check("x0_pre_a0", a0, 32'd7);
    step(8);
    check("x0_reads_zero", a0, 32'd0);
    step(1);
    check("ill_not_yet", {31'b0, halted}, 32'h0);
    step(1);
    check("ill_halted", {31'b0, halted}, 32'h1);
    check("ill_flag", {31'b0, illegal}, 32'h1);
    check("ill_retired", retired, 32'd4);
    step(10);
    check("ill_halted_sticky", {31'b0, halted}, 32'h1);
    check("ill_flag_sticky", {31'b0, illegal}, 32'h1);
    check("ill_pc_held", instr_addr, 32'hC);
    check("ill_retired_held", retired, 32'd4);
    rst = 1'b1;
    step(1);
    check("ill_cleared_by_rst", {30'b0, halted, illegal}, 32'h0);

    // shift is unsupported
    hold_reset();
    imem[0] = 32'h00151513;
    release_reset();
    step(2);
    check("slli_illegal", {30'b0, halted, illegal}, 32'h3);
    check("slli_retired", retired, 32'd1);

    // signed blt skips one instruction
    hold_reset();
    imem[0] = 32'hFFF00513;
    imem[1] = 32'h00054463;
    imem[2] = 32'h00100513;
    release_reset();
    step(9);
    check("blt_a0", a0, 32'hFFFFFFFF);
    check("blt_halt_pc", instr_addr, 32'hC);
    check("blt_retired", retired, 32'd3);

    // jal x10,8
    hold_reset();
    imem[0] = 32'h0080056F;
    imem[1] = 32'h0000007F;
    release_reset();
    step(6);
    check("jal_link", a0, 32'h4);
    check("jal_target", instr_addr, 32'h8);
    check("jal_state", {30'b0, halted, illegal}, 32'h2);

    // jalr x10,0(x1) with x1=13 -> target 12
    hold_reset();
    imem[0] = 32'h00D00093;
    imem[1] = 32'h00008567;
    imem[2] = 32'h0000007F;
    release_reset();
    step(8);
    check("jalr_link", a0, 32'h8);
    step(2);
    check("jalr_target", instr_addr, 32'hC);
    check("jalr_state", {30'b0, halted, illegal}, 32'h2);
    check("jalr_retired", retired, 32'd3);

    // reset during MEM of a store
    hold_reset();
    imem[0] = 32'h00502423;
    release_reset();
    pulses_before = we_pulses;
    step(3);
    check("midsw_we_in_mem", {31'b0, dmem_we}, 32'h1);
    rst = 1'b1;
    #1;
    check("midsw_we_masked", {31'b0, dmem_we}, 32'h0);
    step(1);
    check("midsw_no_pulse", we_pulses - pulses_before, 32'd0);
    check("midsw_dmem_addr", dmem_addr, 32'h0);
    check("midsw_pc", instr_addr, 32'h0);
    check("midsw_retired", retired, 32'h0);
    check("midsw_a0", a0, 32'h0);

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/riscv_multicycle_top.md
# riscv_multicycle_top

Parametrised multi-cycle successor to the single-cycle RV32I top. It executes each instruction over 3–5 states of an explicit FSM, reusing one ALU and one adder, so it adds loads, stores, branches, jumps, halt detection, illegal-opcode flagging and a retired-instruction counter. The register file, ALU and immediate generator are internal. Instruction and data memories are external, with combinational reads.

## Interface
- `ADDRESS_WIDTH`, 32: width of PC, `instr_addr` and `dmem_addr`. Must be ≤ DATA_WIDTH.
- `DATA_WIDTH`, 32: register/ALU width. Instructions are always 32 bits.
- `RESET_PC`, 0: PC value loaded on reset.
- `COUNT_WIDTH`, 32: width of `retired`.
- `clk` in 1: the single clock. All state changes on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `instr_addr` out ADDRESS_WIDTH: byte address of the current instruction (= PC).
- `instr` in 32: instruction word. Combinational read of `instr_addr`.
- `dmem_addr` out ADDRESS_WIDTH: load/store byte address (ALU result, truncated).
- `dmem_wdata` out DATA_WIDTH: store data (rs2).
- `dmem_we` out 1: store strobe, one cycle.
- `dmem_rdata` in DATA_WIDTH: load data. Combinational read of `dmem_addr`.
- `a0` out DATA_WIDTH: registered copy of x10.
- `halted` out 1: sticky halt flag.
- `illegal` out 1: sticky; set when halting on an unsupported opcode.
- `retired` out COUNT_WIDTH: count of completed instructions.

## Operation
- Supported instructions:
  - OP-IMM: addi, slti, xori, ori, andi.
  - OP: add, sub (funct7[5]=1), slt, xor, or, and.
  - lui, lw, sw.
  - Branches: beq, bne, blt (signed).
  - Jumps: jal, jalr.
- Anything else, including shifts and other funct3 values, is illegal.
- FSM states: FETCH, DECODE, EXECUTE, MEM, WB, HALT.
- FETCH → DECODE: latch `instr` into IR.
- At the end of DECODE:
  - Read rs1/rs2 into A/B and build the sign-extended immediate.
  - Word `0x0000006F` (jal x0,0) → HALT.
  - Illegal opcode → HALT and set `illegal`.
  - Otherwise → EXECUTE.
- Branch in EXECUTE:
  - Compare A and B.
  - If taken, PC ← PC+imm; otherwise PC ← PC+4.
  - → FETCH (3 cycles total).
- ALU, lui and jal/jalr in EXECUTE → WB.
- lw/sw in EXECUTE: compute A+imm → MEM.
- sw in MEM: `dmem_we`=1, PC ← PC+4, → FETCH (4 cycles).
- lw in MEM: latch `dmem_rdata` → WB (5 cycles).
- WB:
  - rd ← result. Writes to x0 are discarded; x0 always reads 0.
  - PC ← PC+4 for ALU, lui and lw.
  - jal: rd ← PC+4, PC ← PC+imm.
  - jalr: rd ← PC+4, PC ← (A+imm) with bit 0 cleared.
  - → FETCH.
- `retired` increments on each transition into FETCH. Entering HALT counts as one more retirement. Wraps modulo 2^COUNT_WIDTH.
- HALT:
  - Absorbing until `rst`.
  - No fetches; `instr_addr` holds the halt instruction's PC.
  - No register or memory writes.
- Arithmetic:
  - All ALU and PC arithmetic is modulo 2^width.
  - Results are truncated to ADDRESS_WIDTH for addresses.
  - slt and blt are signed, 1-bit result zero-extended.
- Alignment is not checked. Memory ignores address bits [1:0].

## Timing
- Reset values: PC=RESET_PC, state=FETCH, all registers 0, `a0`=0, `halted`=0, `illegal`=0, `retired`=0, `dmem_we`=0. `dmem_addr` and `dmem_wdata` are 0.
- `rst` mid-instruction aborts it with no partial effects. If `rst` is high during MEM of a sw, `dmem_we` is forced 0 in that cycle.
- First FETCH is the cycle after `rst` deasserts.
- `dmem_we` is a registered, glitch-free strobe, high exactly one cycle per sw. `dmem_addr` and `dmem_wdata` are stable in that cycle.
- `a0` updates the cycle after a WB that writes x10.
- `halted` rises the cycle after the halt instruction's DECODE.
- Latency per instruction: branch 3 cycles, ALU/lui/jal/jalr/sw 4, lw 5. Halt takes 2 cycles to reach HALT.

## Test plan
- Reset: hold `rst` 2 cycles with random `instr` → all outputs at reset values and `instr_addr`=RESET_PC. Drop reset → first fetch at RESET_PC.
- Single ALU op: `00500513` (addi x10,x0,5) then `0000006F` → `a0`=5 after 4 cycles, `retired`=2, `halted`=1, `illegal`=0.
- Countdown loop:
  - Program: `00300513`, `FFF50513`, `FE051EE3` (bne x10,x0,-4), `0000006F`.
  - Required: `a0` steps 3→2→1→0, `halted` high 27 cycles after reset release, `retired`=8.
- Store/load:
  - Program: `123452B7` (lui x5), `00502423` (sw x5,8(x0)), `00802503` (lw x10,8(x0)), halt; `dmem_rdata`=`DEADBEEF`.
  - Required: one `dmem_we` pulse with `dmem_addr`=8 and `dmem_wdata`=`12345000`, then `a0`=`DEADBEEF`.
- Illegal/x0:
  - `00500013` (addi x0,x0,5) followed by opcode `0x7F` → x0 reads 0, `halted`=1 and `illegal`=1, both sticky until reset.
- Reset mid-sw: assert `rst` during MEM of `00502423` → `dmem_we` never goes high; outputs return to reset values.
